// File: rtl/tile_scheduler.sv
// tile_scheduler: bins each triangle to the screen tiles its bounding box covers and feeds them to a raster core.
// Statistics counters are built only when TILE_SCHED_STATS_EN is defined.
module tile_scheduler #(
    parameter int TILE_COLS         = 40,
    parameter int TILE_ROWS         = 30,
    parameter int TILE_SHIFT        = 4,
    parameter int TILE_COLUMNS_BITS = 6,
    parameter int TILE_ROWS_BITS    = 5,
    parameter int FX_TOTAL_BITS     = 16,
    parameter int FX_FRAC_BITS      = 4,
    parameter int COLOR_BITS        = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                tri_vld,
    output logic                                tri_rdy,
    input  logic signed [FX_TOTAL_BITS-1:0]     tri_v0_x,
    input  logic signed [FX_TOTAL_BITS-1:0]     tri_v0_y,
    input  logic signed [FX_TOTAL_BITS-1:0]     tri_v0_z,
    input  logic signed [FX_TOTAL_BITS-1:0]     tri_v1_x,
    input  logic signed [FX_TOTAL_BITS-1:0]     tri_v1_y,
    input  logic signed [FX_TOTAL_BITS-1:0]     tri_v1_z,
    input  logic signed [FX_TOTAL_BITS-1:0]     tri_v2_x,
    input  logic signed [FX_TOTAL_BITS-1:0]     tri_v2_y,
    input  logic signed [FX_TOTAL_BITS-1:0]     tri_v2_z,
    input  logic        [COLOR_BITS-1:0]        tri_color,
    input  logic                                flush_req,
    output logic                                flush_done,
    output logic                                ras_vld,
    input  logic                                ras_rdy,
    output logic signed [FX_TOTAL_BITS-1:0]     ras_v0_x,
    output logic signed [FX_TOTAL_BITS-1:0]     ras_v0_y,
    output logic signed [FX_TOTAL_BITS-1:0]     ras_v0_z,
    output logic signed [FX_TOTAL_BITS-1:0]     ras_v1_x,
    output logic signed [FX_TOTAL_BITS-1:0]     ras_v1_y,
    output logic signed [FX_TOTAL_BITS-1:0]     ras_v1_z,
    output logic signed [FX_TOTAL_BITS-1:0]     ras_v2_x,
    output logic signed [FX_TOTAL_BITS-1:0]     ras_v2_y,
    output logic signed [FX_TOTAL_BITS-1:0]     ras_v2_z,
    output logic        [COLOR_BITS-1:0]        ras_color,
    output logic        [TILE_COLUMNS_BITS-1:0] ras_tile_x,
    output logic        [TILE_ROWS_BITS-1:0]    ras_tile_y,
    output logic                                busy,
    output logic        [15:0]                  stat_tri,
    output logic        [15:0]                  stat_tile,
    output logic        [15:0]                  stat_cull
);

    localparam int SH = FX_FRAC_BITS + TILE_SHIFT;
    localparam int TW = FX_TOTAL_BITS - SH;

    typedef logic signed [FX_TOTAL_BITS-1:0] fx_t;
    typedef logic signed [TW-1:0]            tidx_t;
    typedef enum logic [1:0] {IDLE, BBOX, DISPATCH, FLUSH} state_t;

    localparam tidx_t COL_LAST = tidx_t'(TILE_COLS - 1);
    localparam tidx_t ROW_LAST = tidx_t'(TILE_ROWS - 1);
    localparam logic [TILE_COLUMNS_BITS-1:0] COL_END = TILE_COLUMNS_BITS'(TILE_COLS - 1);
    localparam logic [TILE_ROWS_BITS-1:0]    ROW_END = TILE_ROWS_BITS'(TILE_ROWS - 1);
    localparam fx_t FX_ONE = fx_t'(1 << FX_FRAC_BITS);
    localparam fx_t FX_Z   = fx_t'(128 << FX_FRAC_BITS);

    function automatic tidx_t to_tile(input fx_t v);
        return tidx_t'(v >>> SH);
    endfunction

    function automatic tidx_t min3(input tidx_t a, input tidx_t b, input tidx_t c);
        tidx_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic tidx_t max3(input tidx_t a, input tidx_t b, input tidx_t c);
        tidx_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    state_t                       state;
    logic                         loading;
    logic                         culled;
    logic [TILE_COLUMNS_BITS-1:0] bb_min_x, bb_max_x;
    logic [TILE_ROWS_BITS-1:0]    bb_min_y, bb_max_y;
    logic [TILE_COLUMNS_BITS-1:0] last_x;
    logic [TILE_ROWS_BITS-1:0]    last_y;

    tidx_t mn_x, mx_x, mn_y, mx_y;
    tidx_t lo_x, hi_x, lo_y, hi_y;
    logic  cull_c;
    logic  flush_wrap;

    // Bounding box in tile units, computed from the captured triangle held in the ras_* registers.
    always_comb begin
        mn_x   = min3(to_tile(ras_v0_x), to_tile(ras_v1_x), to_tile(ras_v2_x));
        mx_x   = max3(to_tile(ras_v0_x), to_tile(ras_v1_x), to_tile(ras_v2_x));
        mn_y   = min3(to_tile(ras_v0_y), to_tile(ras_v1_y), to_tile(ras_v2_y));
        mx_y   = max3(to_tile(ras_v0_y), to_tile(ras_v1_y), to_tile(ras_v2_y));
        cull_c = mx_x[TW-1] || mx_y[TW-1] || (mn_x > COL_LAST) || (mn_y > ROW_LAST);
        lo_x   = mn_x[TW-1] ? '0 : mn_x;
        lo_y   = mn_y[TW-1] ? '0 : mn_y;
        hi_x   = (mx_x > COL_LAST) ? COL_LAST : mx_x;
        hi_y   = (mx_y > ROW_LAST) ? ROW_LAST : mx_y;
    end

    assign flush_wrap = (last_x == COL_END) && (last_y == ROW_END);
    assign tri_rdy    = (state == IDLE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            loading    <= 1'b0;
            culled     <= 1'b0;
            bb_min_x   <= '0;
            bb_max_x   <= '0;
            bb_min_y   <= '0;
            bb_max_y   <= '0;
            last_x     <= '0;
            last_y     <= '0;
            flush_done <= 1'b0;
            ras_vld    <= 1'b0;
            ras_v0_x   <= '0;
            ras_v0_y   <= '0;
            ras_v0_z   <= '0;
            ras_v1_x   <= '0;
            ras_v1_y   <= '0;
            ras_v1_z   <= '0;
            ras_v2_x   <= '0;
            ras_v2_y   <= '0;
            ras_v2_z   <= '0;
            ras_color  <= '0;
            ras_tile_x <= '0;
            ras_tile_y <= '0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tri_vld) begin
                        ras_v0_x  <= tri_v0_x;
                        ras_v0_y  <= tri_v0_y;
                        ras_v0_z  <= tri_v0_z;
                        ras_v1_x  <= tri_v1_x;
                        ras_v1_y  <= tri_v1_y;
                        ras_v1_z  <= tri_v1_z;
                        ras_v2_x  <= tri_v2_x;
                        ras_v2_y  <= tri_v2_y;
                        ras_v2_z  <= tri_v2_z;
                        ras_color <= tri_color;
                        state     <= BBOX;
                    end else if (flush_req) begin
                        // Degenerate one-pixel triangle aimed at a tile other than the open one.
                        ras_v0_x   <= '0;
                        ras_v0_y   <= '0;
                        ras_v0_z   <= FX_Z;
                        ras_v1_x   <= '0;
                        ras_v1_y   <= FX_ONE;
                        ras_v1_z   <= FX_Z;
                        ras_v2_x   <= FX_ONE;
                        ras_v2_y   <= '0;
                        ras_v2_z   <= FX_Z;
                        ras_color  <= '0;
                        ras_tile_x <= flush_wrap ? '0 : COL_END;
                        ras_tile_y <= flush_wrap ? '0 : ROW_END;
                        ras_vld    <= 1'b1;
                        state      <= FLUSH;
                    end
                end
                BBOX: begin
                    culled   <= cull_c;
                    bb_min_x <= lo_x[TILE_COLUMNS_BITS-1:0];
                    bb_max_x <= hi_x[TILE_COLUMNS_BITS-1:0];
                    bb_min_y <= lo_y[TILE_ROWS_BITS-1:0];
                    bb_max_y <= hi_y[TILE_ROWS_BITS-1:0];
                    loading  <= 1'b1;
                    state    <= DISPATCH;
                end
                DISPATCH: begin
                    // First DISPATCH cycle loads the cursor from the registered box.
                    if (loading) begin
                        loading <= 1'b0;
                        if (culled) begin
                            state <= IDLE;
                        end else begin
                            ras_tile_x <= bb_min_x;
                            ras_tile_y <= bb_min_y;
                            ras_vld    <= 1'b1;
                        end
                    end else if (ras_rdy) begin
                        last_x <= ras_tile_x;
                        last_y <= ras_tile_y;
                        if (ras_tile_x == bb_max_x) begin
                            if (ras_tile_y == bb_max_y) begin
                                ras_vld <= 1'b0;
                                state   <= IDLE;
                            end else begin
                                ras_tile_x <= bb_min_x;
                                ras_tile_y <= ras_tile_y + 1'b1;
                            end
                        end else begin
                            ras_tile_x <= ras_tile_x + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (ras_rdy) begin
                        ras_vld    <= 1'b0;
                        flush_done <= 1'b1;
                        last_x     <= ras_tile_x;
                        last_y     <= ras_tile_y;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TILE_SCHED_STATS_EN
    logic ev_tri, ev_tile, ev_cull;

    assign ev_tri  = (state == IDLE) && tri_vld;
    assign ev_tile = ras_vld && ras_rdy;
    assign ev_cull = (state == DISPATCH) && loading && culled;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_tri  <= '0;
            stat_tile <= '0;
            stat_cull <= '0;
        end else begin
            if (ev_tri && (stat_tri != 16'hFFFF))
                stat_tri <= stat_tri + 16'd1;
            if (ev_tile && (stat_tile != 16'hFFFF))
                stat_tile <= stat_tile + 16'd1;
            if (ev_cull && (stat_cull != 16'hFFFF))
                stat_cull <= stat_cull + 16'd1;
        end
    end
`else
    assign stat_tri  = '0;
    assign stat_tile = '0;
    assign stat_cull = '0;
`endif

endmodule
